// File: rtl/led_pkg.sv
// Shared types for the LED activity monitor: FSM state encodings and the
// LED state values carried on LED_IF.
package led_pkg;

  typedef enum logic [1:0] {
    LED_STATE_OFF   = 2'd0,
    LED_STATE_ON    = 2'd1,
    LED_STATE_BLINK = 2'd2
  } LED_STATE_t;

  typedef enum logic [1:0] {
    N_IDLE = 2'd0,
    N_BUSY = 2'd1,
    N_HOLD = 2'd2
  } NEXTOR_STATE_t;

  typedef enum logic [1:0] {
    B_WAIT   = 2'd0,
    B_ACTIVE = 2'd1,
    B_DONE   = 2'd2
  } BOOT_STATE_t;

  function automatic LED_STATE_t led_on_off(input logic on);
    return on ? LED_STATE_ON : LED_STATE_OFF;
  endfunction

endpackage

// File: rtl/led_if.sv
// LED state stream between an activity source (HOST) and the LED controller
// (DEVICE).
interface LED_IF;
  import led_pkg::*;

  LED_STATE_t State;

  modport HOST   (output State);
  modport DEVICE (input  State);
endinterface

// File: rtl/led_stretch_counter.sv
// Loadable down-counter that sticks at zero; load wins over decrement.
module led_stretch_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_activity_monitor.sv
// Turns TF access strobes and boot ROM activity into LedNextor / LedBoot states.
// Optional error-hold on LedBoot is enabled with macro LED_ERROR_HOLD_EN.
//
// state    | meaning
// N_IDLE   | no TF activity, LedNextor off
// N_BUSY   | TF command/transaction in progress, LedNextor on
// N_HOLD   | activity ended, stretching ON for MIN_ON cycles
// B_WAIT   | reset, no boot ROM read seen yet, LedBoot on
// B_ACTIVE | boot reads ongoing, idle timer running, LedBoot on
// B_DONE   | boot finished (handoff or idle timeout), LedBoot off
module led_activity_monitor
  import led_pkg::*;
#(
  parameter int MIN_ON    = 1024,
  parameter int BOOT_IDLE = 2_148_000,
  parameter int ERR_HOLD  = 10_740_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SdAccess,
  input  logic SdBusy,
  input  logic BootAccess,
  input  logic BootDone,
  input  logic SdError,
  LED_IF.HOST  LedNextor,
  LED_IF.HOST  LedBoot
);

  localparam int HOLD_W = $clog2(MIN_ON + 1);
  localparam int IDLE_W = $clog2(BOOT_IDLE + 1);

  NEXTOR_STATE_t     n_state, n_next;
  BOOT_STATE_t       b_state, b_next;
  logic [IDLE_W-1:0] idle_cnt, idle_next;
  logic              hold_load, hold_zero;
  logic              err_on;
  LED_STATE_t        led_nextor_q, led_nextor_d;
  LED_STATE_t        led_boot_q, led_boot_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      n_state      <= N_IDLE;
      b_state      <= B_WAIT;
      idle_cnt     <= '0;
      led_nextor_q <= LED_STATE_OFF;
      led_boot_q   <= LED_STATE_ON;
    end else begin
      n_state      <= n_next;
      b_state      <= b_next;
      idle_cnt     <= idle_next;
      led_nextor_q <= led_nextor_d;
      led_boot_q   <= led_boot_d;
    end
  end

  // Re-trigger from N_HOLD leaves the counter alone; it is reloaded when busy ends.
  always_comb begin
    n_next    = n_state;
    hold_load = 1'b0;
    case (n_state)
      N_IDLE: if (SdAccess || SdBusy) n_next = N_BUSY;
      N_BUSY: begin
        if (!SdBusy) begin
          hold_load = 1'b1;
          n_next    = N_HOLD;
        end
      end
      N_HOLD: begin
        if (SdAccess || SdBusy) n_next = N_BUSY;
        else if (hold_zero)     n_next = N_IDLE;
      end
      default: n_next = N_IDLE;
    endcase
  end

  led_stretch_counter #(.W(HOLD_W)) u_hold_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (hold_load),
    .load_val (HOLD_W'(MIN_ON - 1)),
    .dec      (n_state == N_HOLD),
    .zero     (hold_zero)
  );

  // BootDone outranks BootAccess; B_DONE only leaves through RESET.
  always_comb begin
    b_next    = b_state;
    idle_next = idle_cnt;
    case (b_state)
      B_WAIT: begin
        if (BootDone) begin
          b_next = B_DONE;
        end else if (BootAccess) begin
          b_next    = B_ACTIVE;
          idle_next = '0;
        end
      end
      B_ACTIVE: begin
        if (BootDone) begin
          b_next = B_DONE;
        end else if (BootAccess) begin
          idle_next = '0;
        end else if (idle_cnt == IDLE_W'(BOOT_IDLE - 1)) begin
          b_next = B_DONE;
        end else if (idle_cnt != IDLE_W'(BOOT_IDLE)) begin
          idle_next = idle_cnt + IDLE_W'(1);
        end
      end
      default: b_next = B_DONE;
    endcase
  end

`ifdef LED_ERROR_HOLD_EN
  localparam int ERR_W = $clog2(ERR_HOLD + 1);
  logic err_zero;

  led_stretch_counter #(.W(ERR_W)) u_err_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (SdError),
    .load_val (ERR_W'(ERR_HOLD - 1)),
    .dec      (1'b1),
    .zero     (err_zero)
  );

  // The output register lags the counter by one cycle, so the pulse covers ERR_HOLD cycles.
  assign err_on = SdError || !err_zero;
`else
  logic unused_err;
  assign unused_err = SdError | (ERR_HOLD == 0);
  assign err_on     = 1'b0;
`endif

  always_comb begin
    led_nextor_d = led_on_off(n_next != N_IDLE);
    led_boot_d   = led_on_off((b_next != B_DONE) || err_on);
  end

  assign LedNextor.State = led_nextor_q;
  assign LedBoot.State   = led_boot_q;

endmodule

// File: tb/tb_led_activity_monitor.sv
// Directed bench for led_activity_monitor with small MIN_ON/BOOT_IDLE/ERR_HOLD.
module tb_led_activity_monitor;
  import led_pkg::*;

  logic CLK = 1'b0;
  logic RESET, SdAccess, SdBusy, BootAccess, BootDone, SdError;
  int   total = 0;
  int   bad   = 0;

  LED_IF led_n ();
  LED_IF led_b ();

  led_activity_monitor #(.MIN_ON(4), .BOOT_IDLE(8), .ERR_HOLD(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SdAccess   (SdAccess),
    .SdBusy     (SdBusy),
    .BootAccess (BootAccess),
    .BootDone   (BootDone),
    .SdError    (SdError),
    .LedNextor  (led_n),
    .LedBoot    (led_b)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL reset_nextor: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
    total++;
    if (led_b.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL reset_boot: got %0d want %0d", led_b.State, LED_STATE_ON);
    end
    RESET = 1'b0;
    tick();
  endtask

  // Isolated strobe: ON for 1 + MIN_ON = 5 cycles.
  task automatic test_nextor_single();
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL single_pre: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
    SdAccess = 1'b1;
    tick();
    SdAccess = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (led_n.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL single_on[%0d]: got %0d want %0d", i, led_n.State, LED_STATE_ON);
      end
      tick();
    end
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL single_off: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
  endtask

  task automatic test_nextor_busy();
    tick();
    SdAccess = 1'b1;
    SdBusy   = 1'b1;
    tick();
    SdAccess = 1'b0;
    for (int i = 0; i < 19; i++) begin
      total++;
      if (led_n.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL busy_on[%0d]: got %0d want %0d", i, led_n.State, LED_STATE_ON);
      end
      tick();
    end
    SdBusy = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (led_n.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL busy_hold[%0d]: got %0d want %0d", i, led_n.State, LED_STATE_ON);
      end
      tick();
    end
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL busy_off: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
    // Re-trigger two cycles into the hold: BUSY, H3, H2, then retrigger gives BUSY+4 more.
    SdAccess = 1'b1;
    tick();
    SdAccess = 1'b0;
    tick();
    tick();
    SdAccess = 1'b1;
    tick();
    SdAccess = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (led_n.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL retrig_on[%0d]: got %0d want %0d", i, led_n.State, LED_STATE_ON);
      end
      tick();
    end
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL retrig_off: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
  endtask

  task automatic test_boot_idle();
    // No BootAccess since reset: still in B_WAIT.
    total++;
    if (led_b.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL boot_wait: got %0d want %0d", led_b.State, LED_STATE_ON);
    end
    for (int k = 0; k < 9; k++) begin
      BootAccess = 1'b1;
      tick();
      BootAccess = 1'b0;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (led_b.State !== LED_STATE_ON) begin
          bad++;
          $display("FAIL boot_active[%0d.%0d]: got %0d want %0d", k, i, led_b.State, LED_STATE_ON);
        end
        tick();
      end
    end
    BootAccess = 1'b1;
    tick();
    BootAccess = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (led_b.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL boot_tail[%0d]: got %0d want %0d", i, led_b.State, LED_STATE_ON);
      end
      tick();
    end
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL boot_timeout: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
    BootAccess = 1'b1;
    tick();
    BootAccess = 1'b0;
    tick();
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL boot_terminal: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
  endtask

  task automatic test_boot_done_priority();
    do_reset();
    BootAccess = 1'b1;
    tick();
    BootAccess = 1'b0;
    tick();
    tick();
    total++;
    if (led_b.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL done_pre: got %0d want %0d", led_b.State, LED_STATE_ON);
    end
    BootAccess = 1'b1;
    BootDone   = 1'b1;
    tick();
    BootAccess = 1'b0;
    BootDone   = 1'b0;
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL done_priority: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    SdBusy = 1'b1;
    tick();
    tick();
    total++;
    if (led_n.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL rst_busy_pre: got %0d want %0d", led_n.State, LED_STATE_ON);
    end
    BootDone = 1'b1;
    tick();
    BootDone = 1'b0;
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL rst_boot_pre: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
    RESET = 1'b1;
    tick();
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL rst_busy_nextor: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
    total++;
    if (led_b.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL rst_busy_boot: got %0d want %0d", led_b.State, LED_STATE_ON);
    end
    RESET = 1'b0;
    tick();
    total++;
    if (led_n.State !== LED_STATE_ON) begin
      bad++;
      $display("FAIL rst_busy_resume: got %0d want %0d", led_n.State, LED_STATE_ON);
    end
    SdBusy = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_error_hold();
    BootDone = 1'b1;
    tick();
    BootDone = 1'b0;
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL err_pre: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
    SdError = 1'b1;
    tick();
    SdError = 1'b0;
`ifdef LED_ERROR_HOLD_EN
    for (int i = 0; i < 6; i++) begin
      total++;
      if (led_b.State !== LED_STATE_ON) begin
        bad++;
        $display("FAIL err_on[%0d]: got %0d want %0d", i, led_b.State, LED_STATE_ON);
      end
      tick();
    end
`else
    for (int i = 0; i < 6; i++) begin
      total++;
      if (led_b.State !== LED_STATE_OFF) begin
        bad++;
        $display("FAIL err_ignored[%0d]: got %0d want %0d", i, led_b.State, LED_STATE_OFF);
      end
      tick();
    end
`endif
    total++;
    if (led_b.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL err_end: got %0d want %0d", led_b.State, LED_STATE_OFF);
    end
    total++;
    if (led_n.State !== LED_STATE_OFF) begin
      bad++;
      $display("FAIL err_nextor: got %0d want %0d", led_n.State, LED_STATE_OFF);
    end
  endtask

  initial begin
    RESET      = 1'b1;
    SdAccess   = 1'b0;
    SdBusy     = 1'b0;
    BootAccess = 1'b0;
    BootDone   = 1'b0;
    SdError    = 1'b0;
    test_reset();
    test_nextor_single();
    test_nextor_busy();
    test_boot_idle();
    test_boot_done_priority();
    test_reset_mid_busy();
    test_error_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
